// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-requester arbiter in front of a single downstream memory port.
//   Requester 0 is instruction fetch, requester 1 is the memory stage.
//   One transaction owns the port from grant until m_data_ok. After it ends
//   there is always one IDLE cycle before the next grant.
//
//   Configuration macro: BUS_ARB_ROUND_ROBIN_EN
//     defined   : on contention, the requester that did not win last time wins.
//     undefined : fixed priority, and the memory stage (index 1) always wins.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   req_valid[1:0]    per-requester request valid
//   req_addr/size/    per-requester request payload
//   strobe/wdata        (strobe == 0 means a read)
//   resp_addr_ok[1:0] address accepted, routed to the owner only
//   resp_data_ok[1:0] transaction complete, routed to the owner only
//   resp_rdata        read data (copy of m_rdata)
//   m_valid/addr/     shared downstream request. While in GRANT the payload
//   size/strobe/wdata   follows the owner's request combinationally.
//   m_addr_ok/        shared downstream response
//   m_data_ok/m_rdata
//   grant_id          current owner index
//   busy              high while a transaction is in flight
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    input  logic [1:0][AW-1:0]       req_addr,
    input  logic [1:0][2:0]          req_size,
    input  logic [1:0][DW/8-1:0]     req_strobe,
    input  logic [1:0][DW-1:0]       req_wdata,
    output logic [1:0]               resp_addr_ok,
    output logic [1:0]               resp_data_ok,
    output logic [DW-1:0]            resp_rdata,
    output logic                     m_valid,
    output logic [AW-1:0]            m_addr,
    output logic [2:0]               m_size,
    output logic [DW/8-1:0]          m_strobe,
    output logic [DW-1:0]            m_wdata,
    input  logic                     m_addr_ok,
    input  logic                     m_data_ok,
    input  logic [DW-1:0]            m_rdata,
    output logic                     grant_id,
    output logic                     busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   pick;
    logic   in_grant;
    logic [1:0] owner_sel;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_owner;
`endif

    // Winner among the current requesters. A lone requester always wins; the
    // policy only matters when both are asking in the same IDLE cycle.
    always_comb begin
        pick = 1'b0;
        unique case (req_valid)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            default: pick = ~last_owner;
`else
            default: pick = 1'b1;
`endif
        endcase
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = GRANT;
                    owner_nxt = pick;
                end
            end
            GRANT: begin
                // The owner may drop req_valid early. The grant is held
                // until the downstream port reports completion.
                if (m_data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // At reset last_owner points at requester 1, so the first contended
    // grant goes to fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         last_owner <= 1'b1;
        else if (state == IDLE && |req_valid) last_owner <= pick;
    end
`endif

    assign in_grant  = (state == GRANT);
    assign owner_sel = owner ? 2'b10 : 2'b01;

    always_comb begin
        m_valid      = in_grant;
        busy         = in_grant;
        grant_id     = owner;
        m_addr       = req_addr[owner];
        m_size       = req_size[owner];
        m_strobe     = req_strobe[owner];
        m_wdata      = req_wdata[owner];
        // Downstream handshakes only reach the owner, and only while granted.
        // Handshakes that arrive during IDLE are dropped here.
        resp_addr_ok = {2{in_grant & m_addr_ok}} & owner_sel;
        resp_data_ok = {2{in_grant & m_data_ok}} & owner_sel;
        resp_rdata   = m_rdata;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Randomized bench for bus_arbiter. The stimulus process drives requests and
//   downstream handshakes. It uses a transaction-level arbitration model to
//   decide the winner of each round and pushes that expectation onto
//   scoreboard queues. A separate monitor pops the queues and compares
//   against the DUT outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    typedef struct {
        logic            id;
        logic [AW-1:0]   addr;
        logic [2:0]      size;
        logic [DW/8-1:0] strobe;
        logic [DW-1:0]   wdata;
    } grant_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] rdata;
    } resp_t;

    logic                 clk;
    logic                 reset;
    logic [1:0]           req_valid;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][2:0]      req_size;
    logic [1:0][DW/8-1:0] req_strobe;
    logic [1:0][DW-1:0]   req_wdata;
    logic [1:0]           resp_addr_ok;
    logic [1:0]           resp_data_ok;
    logic [DW-1:0]        resp_rdata;
    logic                 m_valid;
    logic [AW-1:0]        m_addr;
    logic [2:0]           m_size;
    logic [DW/8-1:0]      m_strobe;
    logic [DW-1:0]        m_wdata;
    logic                 m_addr_ok;
    logic                 m_data_ok;
    logic [DW-1:0]        m_rdata;
    logic                 grant_id;
    logic                 busy;

    bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_strobe(req_strobe), .req_wdata(req_wdata),
        .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok),
        .resp_rdata(resp_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    grant_t sb_grant[$];
    resp_t  sb_resp[$];

    // Reference state, owned by the stimulus process.
    grant_t pay[2];
    logic [1:0] pend;
    logic   last_win;
    logic   exp_active;
    logic   mon_en;

    // Monitor-owned state.
    grant_t cur;
    logic   prev_active;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    function automatic grant_t rand_pay(input logic id);
        grant_t g;
        g.id     = id;
        g.addr   = {$urandom, $urandom};
        g.size   = 3'($urandom_range(0, 3));
        g.strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        g.wdata  = {$urandom, $urandom};
        return g;
    endfunction

    // Arbitration rule, stated at the transaction level.
    function automatic logic winner(input logic [1:0] p, input logic last);
        if (p == 2'b01) return 1'b0;
        if (p == 2'b10) return 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        return ~last;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive_req(input logic i);
        req_addr[i]   = pay[i].addr;
        req_size[i]   = pay[i].size;
        req_strobe[i] = pay[i].strobe;
        req_wdata[i]  = pay[i].wdata;
    endtask

    // Monitor: scoreboard pop/compare on every falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_active && !prev_active) begin
                if (sb_grant.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL grant_queue: got empty expected an entry at %0t", $time);
                end else begin
                    cur = sb_grant.pop_front();
                end
            end
            prev_active = exp_active;
            chk("m_valid", 64'(m_valid), 64'(exp_active));
            chk("busy",    64'(busy),    64'(exp_active));
            if (exp_active) begin
                chk("grant_id", 64'(grant_id), 64'(cur.id));
                chk("m_addr",   m_addr,        cur.addr);
                chk("m_size",   64'(m_size),   64'(cur.size));
                chk("m_strobe", 64'(m_strobe), 64'(cur.strobe));
                chk("m_wdata",  m_wdata,       cur.wdata);
            end
            chk("resp_addr_ok", 64'(resp_addr_ok),
                64'((exp_active && m_addr_ok) ? onehot(cur.id) : 2'b00));
            if (exp_active && m_data_ok) begin
                if (sb_resp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL resp_queue: got empty expected an entry at %0t", $time);
                end else begin
                    resp_t r;
                    r = sb_resp.pop_front();
                    chk("resp_data_ok", 64'(resp_data_ok), 64'(onehot(r.id)));
                    chk("resp_rdata",   resp_rdata,        r.rdata);
                end
            end else begin
                chk("resp_data_ok_idle", 64'(resp_data_ok), 64'd0);
            end
        end else begin
            prev_active = 1'b0;
        end
    end

    // One arbitration round. Entered at posedge+1 with the DUT in IDLE.
    // mode 0: random, 1: fixed fetch read, 2: both requesters contending.
    task automatic run_txn(input int mode);
        logic w;
        int   lat, aok_cyc;
        if (mode == 1) begin
            pay[0] = rand_pay(1'b0);
            pay[0].addr = 64'h8000_0000; pay[0].strobe = 8'h00; pay[0].size = 3'd3;
            pend[0] = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && (mode == 2 || $urandom_range(0, 1) == 1)) begin
                    pay[i] = rand_pay(1'(i)); pend[i] = 1'b1;
                end
            if (pend == 2'b00) begin
                w = 1'($urandom_range(0, 1));
                pay[w] = rand_pay(w); pend[w] = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) drive_req(1'(i));
        req_valid = pend;
        w = winner(pend, last_win);
        last_win = w;
        sb_grant.push_back(pay[w]);
        @(posedge clk); #1;
        exp_active = 1'b1;
        lat     = (mode == 1) ? 3 : $urandom_range(0, 4);
        aok_cyc = (mode == 1) ? 3 : $urandom_range(0, lat);
        for (int c = 0; c <= lat; c++) begin
            m_addr_ok = (c == aok_cyc);
            m_data_ok = (c == lat);
            m_rdata   = (mode == 1) ? 64'h1122 : {$urandom, $urandom};
            if (c == lat) begin
                resp_t r;
                r.id = w; r.rdata = m_rdata;
                sb_resp.push_back(r);
            end
            // The owner may withdraw. The other side may start asking.
            if (mode != 1 && $urandom_range(0, 3) == 0) req_valid[w] = 1'b0;
            if (mode != 1 && !pend[~w] && $urandom_range(0, 3) == 0) begin
                pay[~w] = rand_pay(~w); pend[~w] = 1'b1;
                drive_req(~w); req_valid[~w] = 1'b1;
            end
            @(posedge clk); #1;
        end
        exp_active = 1'b0;
        m_addr_ok  = 1'b0;
        m_data_ok  = 1'b0;
        pend[w]    = 1'b0;
        req_valid  = pend;
        // Stray downstream handshakes during IDLE must not reach requesters.
        if (mode == 0 && $urandom_range(0, 2) == 0) begin
            req_valid = 2'b00;
            m_addr_ok = 1'($urandom_range(0, 1));
            m_data_ok = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            m_addr_ok = 1'b0;
            m_data_ok = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 2'b00; req_addr = '0; req_size = '0;
        req_strobe = '0; req_wdata = '0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        m_rdata = '0; pend = 2'b00; last_win = 1'b1; exp_active = 1'b0;
        mon_en = 1'b0; prev_active = 1'b0;
        cur = '{id: 1'b0, addr: '0, size: '0, strobe: '0, wdata: '0};

        #3;
        chk("rst_m_valid",  64'(m_valid),      64'd0);
        chk("rst_busy",     64'(busy),         64'd0);
        chk("rst_grant_id", 64'(grant_id),     64'd0);
        chk("rst_resp_aok", 64'(resp_addr_ok), 64'd0);
        chk("rst_resp_dok", 64'(resp_data_ok), 64'd0);
        // Requests and handshakes held during reset change nothing.
        req_valid = 2'b11; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_m_valid", 64'(m_valid),      64'd0);
        chk("rst_hold_resp",    64'(resp_data_ok), 64'd0);
        req_valid = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        reset = 1'b1;
        mon_en = 1'b1;

        run_txn(1);
        for (int k = 0; k < 4; k++) run_txn(2);
        for (int k = 0; k < 60; k++) run_txn(0);

        // Reset in the middle of a transaction owned by requester 1.
        mon_en = 1'b0;
        req_valid = 2'b00; pend = 2'b00;
        pay[1] = rand_pay(1'b1); drive_req(1'b1);
        req_valid = 2'b10;
        @(posedge clk); #1;
        chk("pre_rst_m_valid",  64'(m_valid),  64'd1);
        chk("pre_rst_grant_id", 64'(grant_id), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_m_valid",  64'(m_valid),  64'd0);
        chk("async_rst_busy",     64'(busy),     64'd0);
        chk("async_rst_grant_id", 64'(grant_id), 64'd0);
        m_addr_ok = 1'b1; m_data_ok = 1'b1;
        @(posedge clk); #1;
        chk("rst_dok_ignored", 64'(resp_data_ok), 64'd0);
        chk("rst_aok_ignored", 64'(resp_addr_ok), 64'd0);
        chk("rst_stay_idle",   64'(m_valid),      64'd0);
        reset = 1'b1; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        req_valid = 2'b00; pend = 2'b00; last_win = 1'b1; exp_active = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", 64'(m_valid), 64'd0);
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) run_txn(2);
        for (int k = 0; k < 20; k++) run_txn(0);

        @(posedge clk); #1;
        chk("grant_queue_drained", 64'(sb_grant.size()), 64'd0);
        chk("resp_queue_drained",  64'(sb_resp.size()),  64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
